maxpool_binarize: RTL and testbench

- Streaming max-pool plus binarize stage for the binary-NN accelerator; generalises the fixed single-cycle 7-input compare block.
- Each beat carries LANES signed activations. Their max is accumulated over POOL_BEATS beats to form one pooling window.
- The window max is doubled and compared against a per-channel signed threshold pair, with sign-selected polarity, to emit one binary output per window.
- Sits between the conv/accumulate datapath and the binary activation buffer.

---
 rtl/maxpool_binarize.sv | 160 ++++++++++++++++
 tb/tb_maxpool_binarize.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_binarize.sv
// Streaming max-pool + binarize stage.
// Each accepted beat carries LANES signed activations. The beat max is taken,
// accumulated over POOL_BEATS beats into a window max, doubled and compared
// against the per-channel threshold pair selected by the sign of the window max.
// Pipeline: A (beat max) -> ACC (running max) -> B (window + threshold) -> OUT.
// The last beat of a window accepted at edge t gives out_valid after edge t+3.
module maxpool_binarize #(
    parameter int DW         = 9,
    parameter int LANES      = 7,
    parameter int POOL_BEATS = 2,
    parameter int CH         = 8,
    parameter int TW         = 11,   // must be >= DW+2 so that 2*max fits
    localparam int CW        = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   in_data,
    input  logic                  thr_we,
    input  logic [CW-1:0]         thr_addr,
    input  logic [2*TW+1:0]       thr_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_bit,
    output logic [CW-1:0]         out_ch
);

    localparam int BW = (POOL_BEATS > 1) ? $clog2(POOL_BEATS) : 1;
    localparam int EW = 2*TW + 2;

    logic stall, accept;

    // The whole pipeline freezes while a result waits at the output.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready && !clr;

    // Stage A: signed max over the lanes of the incoming beat (lane 0 in MSBs).
    logic signed [DW-1:0] lane_max;
    always_comb begin
        lane_max = $signed(in_data[LANES*DW-1 -: DW]);
        for (int i = 1; i < LANES; i++) begin
            if ($signed(in_data[(LANES-i)*DW-1 -: DW]) > lane_max)
                lane_max = $signed(in_data[(LANES-i)*DW-1 -: DW]);
        end
    end

    logic                 a_vld, a_last;
    logic signed [DW-1:0] a_max;
    logic [BW-1:0]        beat_cnt;

    // Stage A register and beat counter; a_last tags the closing beat of a window.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            a_vld    <= 1'b0;
            a_last   <= 1'b0;
            a_max    <= '0;
            beat_cnt <= '0;
        end else if (!stall) begin
            a_vld <= accept;
            if (accept) begin
                a_max    <= lane_max;
                a_last   <= (beat_cnt == BW'(POOL_BEATS-1));
                beat_cnt <= (beat_cnt == BW'(POOL_BEATS-1)) ? '0 : beat_cnt + BW'(1);
            end
        end
    end

    // Running max: the first beat of a window overwrites, later beats compare.
    logic signed [DW-1:0] acc, acc_nxt;
    logic                 acc_first, acc_done;

    always_comb begin
        acc_nxt = (acc_first || (a_max > acc)) ? a_max : acc;
    end

    // Accumulator register; acc_done marks that acc holds a finished window.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc       <= '0;
            acc_first <= 1'b1;
            acc_done  <= 1'b0;
        end else if (!stall) begin
            acc_done <= a_vld && a_last;
            if (a_vld) begin
                acc       <= acc_nxt;
                acc_first <= a_last;
            end
        end
    end

    // Threshold table: {plus_sign, thr_plus, minus_sign, thr_minus} per channel.
    logic [EW-1:0] thr_mem [CH];

    // Table writes land at the edge; a same-edge read in stage B sees the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) thr_mem[i] <= '0;
        end else if (thr_we && (int'(thr_addr) < CH)) begin
            thr_mem[thr_addr] <= thr_data;
        end
    end

    logic                 b_vld;
    logic signed [DW-1:0] b_max;
    logic [CW-1:0]        b_ch, ch_cnt;
    logic [EW-1:0]        b_thr;

    // Stage B: capture the window max with its channel and threshold entry.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            b_vld  <= 1'b0;
            b_max  <= '0;
            b_ch   <= '0;
            b_thr  <= '0;
            ch_cnt <= '0;
        end else if (!stall) begin
            b_vld <= acc_done;
            if (acc_done) begin
                b_max  <= acc;
                b_ch   <= ch_cnt;
                b_thr  <= thr_mem[ch_cnt];
                ch_cnt <= (ch_cnt == CW'(CH-1)) ? '0 : ch_cnt + CW'(1);
            end
        end
    end

    // Compare: 2*max against the sign-selected threshold; sign picks polarity.
    logic signed [TW-1:0] v, thr_sel;
    logic                 sign_sel, gt;
    always_comb begin
        v = {{(TW-DW-1){b_max[DW-1]}}, b_max, 1'b0};
        if (b_max[DW-1]) begin
            sign_sel = b_thr[TW];
            thr_sel  = $signed(b_thr[TW-1:0]);
        end else begin
            sign_sel = b_thr[EW-1];
            thr_sel  = $signed(b_thr[EW-2:TW+1]);
        end
        gt = (v > thr_sel);
    end

    // Output register; holds its contents until the consumer takes them.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_ch    <= '0;
        end else if (!stall) begin
            out_valid <= b_vld;
            if (b_vld) begin
                out_bit <= gt ^ ~sign_sel;
                out_ch  <= b_ch;
            end
        end
    end

endmodule

// File: tb/tb_maxpool_binarize.sv
// Bench for maxpool_binarize: directed table, hand sequences for clr/rst/
// threshold timing, and randomized streaming against a window-level model.
module tb_maxpool_binarize;

    localparam int DW = 9, LANES = 7, POOL_BEATS = 2, CH = 8, TW = 11;
    localparam int CW = 3, EW = 2*TW + 2;

    logic clk = 1'b0;
    logic rst, clr, in_valid, in_ready, thr_we, out_valid, out_ready, out_bit;
    logic [LANES*DW-1:0] in_data;
    logic [CW-1:0]       thr_addr, out_ch;
    logic [EW-1:0]       thr_data;

    always #5 clk = ~clk;

    maxpool_binarize #(.DW(DW), .LANES(LANES), .POOL_BEATS(POOL_BEATS), .CH(CH), .TW(TW)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .thr_we(thr_we), .thr_addr(thr_addr), .thr_data(thr_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit), .out_ch(out_ch)
    );

    int checks = 0, errors = 0;

    typedef struct { bit b; int ch; } exp_t;
    exp_t exp_q[$];
    int   ch_log[$];
    logic [EW-1:0] thr_m [CH];
    int win_cnt = 0, win_max = 0, ch_m = 0, acc_cnt = 0;
    bit prev_stall = 0, prev_rc = 0;
    logic prev_bit;
    logic [CW-1:0] prev_ch;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int lane_of(logic [LANES*DW-1:0] d, int i);
        logic signed [DW-1:0] x;
        x = d[(LANES-1-i)*DW +: DW];
        return int'(x);
    endfunction

    // Expected bit straight from the rules: 2*max vs the sign-selected threshold.
    function automatic bit ref_bit(int mx, logic [EW-1:0] t);
        logic signed [TW-1:0] tp, tm;
        int v, th;
        bit s;
        tp = t[EW-2:TW+1];
        tm = t[TW-1:0];
        v  = 2 * mx;
        if (mx >= 0) begin s = t[EW-1]; th = int'(tp); end
        else         begin s = t[TW];   th = int'(tm); end
        return s ? (v > th) : (v <= th);
    endfunction

    function automatic logic [EW-1:0] mk_thr(int ps, int tp, int ms, int tm);
        logic [TW-1:0] a, b;
        a = tp[TW-1:0];
        b = tm[TW-1:0];
        return {ps[0], a, ms[0], b};
    endfunction

    // Beat whose lane max is m: one (or every) lane is m, the rest are <= m.
    function automatic logic [LANES*DW-1:0] mk_beat(int m, bit all);
        logic [LANES*DW-1:0] d;
        int pos, x;
        pos = int'($urandom_range(0, LANES-1));
        for (int i = 0; i < LANES; i++) begin
            if (all || i == pos) x = m;
            else x = -256 + int'($urandom_range(0, m + 256));
            d[(LANES-1-i)*DW +: DW] = x[DW-1:0];
        end
        return d;
    endfunction

    function automatic logic [LANES*DW-1:0] rnd_beat();
        logic [LANES*DW-1:0] d;
        for (int i = 0; i < LANES; i++) d[i*DW +: DW] = DW'($urandom_range(0, 511));
        return d;
    endfunction

    function automatic void flush();
        exp_q.delete();
        win_cnt = 0;
        ch_m    = 0;
    endfunction

    // One clock: observe handshakes just before the edge, update model, return #1 after.
    task automatic step();
        @(negedge clk);
        if (prev_stall && !prev_rc) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_bit", int'(out_bit), int'(prev_bit));
            check("hold_ch", int'(out_ch), int'(prev_ch));
        end
        prev_stall = out_valid && !out_ready;
        prev_rc    = rst || clr;
        prev_bit   = out_bit;
        prev_ch    = out_ch;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_extra: got output ch %0d, required none", out_ch);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_bit", int'(out_bit), int'(e.b));
                check("sb_ch", int'(out_ch), e.ch);
                ch_log.push_back(int'(out_ch));
            end
        end
        if (rst) begin
            flush();
            for (int i = 0; i < CH; i++) thr_m[i] = '0;
        end else begin
            if (thr_we) thr_m[thr_addr] = thr_data;
            if (clr) flush();
            else if (in_valid && in_ready) begin
                int m;
                m = lane_of(in_data, 0);
                for (int i = 1; i < LANES; i++) if (lane_of(in_data, i) > m) m = lane_of(in_data, i);
                acc_cnt++;
                if (win_cnt == 0 || m > win_max) win_max = m;
                win_cnt++;
                if (win_cnt == POOL_BEATS) begin
                    exp_q.push_back('{ref_bit(win_max, thr_m[ch_m]), ch_m});
                    ch_m    = (ch_m + 1) % CH;
                    win_cnt = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_thr(int a, logic [EW-1:0] d);
        thr_we = 1'b1; thr_addr = CW'(a); thr_data = d;
        step();
        thr_we = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic wait_out(string nm, output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin step(); lat++; end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no out_valid in %0d cycles, required one", nm, lat);
        end
    endtask

    task automatic send_window(int m0, int m1);
        in_valid = 1'b1; in_data = mk_beat(m0, 0); step();
        in_data = mk_beat(m1, 0); step();
        in_valid = 1'b0;
    endtask

    typedef struct { int m0; int m1; bit all; bit eb; int ech; } vec_t;
    vec_t tbl[7];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst = 1; clr = 0; in_valid = 0; in_data = '0;
        thr_we = 0; thr_addr = '0; thr_data = '0; out_ready = 1;
        step(); step();
        rst = 0;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_bit", int'(out_bit), 0);
        check("rst_out_ch", int'(out_ch), 0);
        check("rst_in_ready", int'(in_ready), 1);

        // Directed windows, all channels {0, 20, 1, -10}
        tbl[0] = '{5, 12, 0, 0, 0};      // v=24 > 20, sign 0
        tbl[1] = '{10, -7, 0, 1, 1};     // v=20 tie -> bit 1
        tbl[2] = '{-3, -50, 0, 1, 2};    // v=-6 > -10, sign 1
        tbl[3] = '{-256, -256, 1, 0, 3}; // v=-512
        tbl[4] = '{255, 255, 1, 0, 4};   // v=510
        tbl[5] = '{-5, -6, 0, 0, 5};     // v=-10 tie on minus side
        tbl[6] = '{0, -1, 0, 1, 6};      // max 0 uses plus side
        for (int i = 0; i < CH; i++) write_thr(i, mk_thr(0, 20, 1, -10));
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = mk_beat(tbl[i].m0, tbl[i].all);
            check($sformatf("tbl%0d_in_ready", i), int'(in_ready), 1);
            step();
            in_data = mk_beat(tbl[i].m1, tbl[i].all); step();
            in_valid = 1'b0;
            wait_out($sformatf("tbl%0d", i), lat);
            check($sformatf("tbl%0d_latency", i), lat, 3);
            check($sformatf("tbl%0d_bit", i), int'(out_bit), int'(tbl[i].eb));
            check($sformatf("tbl%0d_ch", i), int'(out_ch), tbl[i].ech);
        end
        step();

        // Back-to-back windows with a 5-cycle output stall in the middle
        for (int i = 0; i < CH; i++)
            write_thr(i, mk_thr(int'($urandom_range(0, 1)), int'($urandom_range(0, 1200)) - 600,
                                int'($urandom_range(0, 1)), int'($urandom_range(0, 1200)) - 600));
        pulse_clr();
        ch_log.delete();
        acc_cnt = 0;
        begin
            bit stalled;
            int sleft;
            logic hb;
            logic [CW-1:0] hc;
            stalled = 0; sleft = 0;
            for (int cyc = 0; cyc < 300 && ch_log.size() < 9; cyc++) begin
                if (out_ready == 1'b0) begin
                    check("s4_in_ready", int'(in_ready), 0);
                    check("s4_stall_valid", int'(out_valid), 1);
                    check("s4_stall_bit", int'(out_bit), int'(hb));
                    check("s4_stall_ch", int'(out_ch), int'(hc));
                end
                if (sleft > 0) begin
                    sleft--;
                    if (sleft == 0) out_ready = 1'b1;
                end else if (!stalled && out_valid && ch_log.size() >= 3) begin
                    stalled = 1; sleft = 5; out_ready = 1'b0; hb = out_bit; hc = out_ch;
                end
                in_valid = (acc_cnt < 2 * 9);
                in_data  = rnd_beat();
                step();
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        check("s4_count", ch_log.size(), 9);
        for (int i = 0; i < ch_log.size() && i < 9; i++)
            check($sformatf("s4_ch%0d", i), ch_log[i], i % CH);

        // clr after the first beat of a window drops it
        write_thr(0, mk_thr(0, 20, 1, -10));
        pulse_clr();
        in_valid = 1'b1; in_data = mk_beat(100, 1); step();
        clr = 1'b1; in_data = mk_beat(100, 1); step(); clr = 1'b0;
        in_valid = 1'b0;
        send_window(5, 8);               // fresh window: v=16 <= 20
        wait_out("clr", lat);
        check("clr_bit", int'(out_bit), 1);
        check("clr_ch", int'(out_ch), 0);
        step();

        // rst while a result is held at the output
        send_window(7, 3);
        wait_out("prerst", lat);
        out_ready = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        out_ready = 1'b1;
        check("rst_mid_out_valid", int'(out_valid), 0);
        send_window(5, -20);             // thresholds now zero: v=10 > 0, sign 0
        wait_out("postrst", lat);
        check("rst_thr_bit", int'(out_bit), 0);
        check("rst_thr_ch", int'(out_ch), 0);
        step();

        // Threshold write in the cycle stage B captures ch0 is not seen
        write_thr(0, mk_thr(0, 20, 1, -10));
        pulse_clr();
        send_window(15, 1);              // last beat accepted at edge t
        step();                          // edge t+1
        thr_we = 1'b1; thr_addr = '0; thr_data = mk_thr(0, 40, 1, -10);
        step();                          // edge t+2: capture and write together
        thr_we = 1'b0;
        wait_out("s6_old", lat);
        check("s6_old_thr_bit", int'(out_bit), 0);
        pulse_clr();
        send_window(15, 1);
        wait_out("s6_new", lat);
        check("s6_new_thr_bit", int'(out_bit), 1);
        check("s6_new_thr_ch", int'(out_ch), 0);
        step();

        // Random traffic with random backpressure against the model
        for (int i = 0; i < CH; i++)
            write_thr(i, mk_thr(int'($urandom_range(0, 1)), int'($urandom_range(0, 1200)) - 600,
                                int'($urandom_range(0, 1)), int'($urandom_range(0, 1200)) - 600));
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = rnd_beat();
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 30 && (exp_q.size() > 0 || out_valid); n++) step();
        check("rand_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
